// File: rtl/step_move_seq_pkg.sv
// Shared types and defaults for the step/direction move sequencer.
package step_move_seq_pkg;

    localparam int MIN_PERIOD_DEF = 4;
    localparam int DIR_SETUP_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DSETUP = 3'd2,
        HIGH   = 3'd3,
        LOW    = 3'd4
    } state_t;

    typedef struct packed {
        logic [31:0] period;
        logic [15:0] steps;
        logic        dir;
    } cmd_t;

endpackage

// File: rtl/step_cmd_fifo.sv
// Synchronous command FIFO with flush; rdata shows the head entry while not empty.
module step_cmd_fifo
    import step_move_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       wr,
    input  cmd_t       wdata,
    input  logic       rd,
    output cmd_t       rdata,
    output logic       full,
    output logic       empty,
    output logic [4:0] level
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [4:0]    count;
    logic          do_wr;
    logic          do_rd;

    assign full  = (count == 5'(DEPTH));
    assign empty = (count == 5'd0);
    assign level = count;
    assign rdata = mem[rptr];
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + AW'(1);
            if (do_rd) rptr <= rptr + AW'(1);
            count <= count + 5'(do_wr) - 5'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !rst && !flush) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/step_move_seq.sv
// Queued stepper move sequencer: pops {period, steps, dir} commands and emits ST_CLK pulses.
// Optional feature: define STEP_POS_CNT_EN to add the signed position counter output.
module step_move_seq
    import step_move_seq_pkg::*;
#(
    parameter int QDEPTH     = 4,
    parameter int DIR_SETUP  = DIR_SETUP_DEF,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic               LClk,
    input  logic               LRst,
    input  logic               cmd_wr,
    input  logic [31:0]        cmd_period,
    input  logic [15:0]        cmd_steps,
    input  logic               cmd_dir,
    input  logic               abort,
    output logic               cmd_full,
    output logic               cmd_ovf,
    output logic [4:0]         q_level,
    output logic               ST_CLK,
    output logic               ST_DIR,
    output logic               ST_ENB,
    output logic               busy,
    output logic               move_done,
`ifdef STEP_POS_CNT_EN
    output logic signed [31:0] position,
`endif
    output state_t             fsm_state
);
    localparam logic [31:0] SETUP_LOAD = 32'(DIR_SETUP - 1);
    localparam logic [31:0] MIN_P      = 32'(MIN_PERIOD);

    state_t      state, state_next;
    cmd_t        cur;
    cmd_t        fifo_rdata;
    logic        fifo_empty;
    logic        wr_acc;
    logic        pop;
    logic        done_evt;
    logic        dir_next;
    logic        enb_next;
    logic [31:0] timer, timer_next;
    logic [15:0] remain, remain_next;
    logic [31:0] eff_period;
    logic [31:0] half_len;
    logic [31:0] low_len;

    // abort discards any same-cycle write; full writes are dropped inside the FIFO
    assign wr_acc = cmd_wr && !cmd_full && !abort;

    step_cmd_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk   (LClk),
        .rst   (LRst),
        .flush (abort),
        .wr    (cmd_wr && !abort),
        .wdata ('{period: cmd_period, steps: cmd_steps, dir: cmd_dir}),
        .rd    (pop),
        .rdata (fifo_rdata),
        .full  (cmd_full),
        .empty (fifo_empty),
        .level (q_level)
    );

    assign eff_period = (cur.period < MIN_P) ? MIN_P : cur.period;
    assign half_len   = eff_period >> 1;
    assign low_len    = eff_period - half_len;
    assign busy       = (state != IDLE) || !fifo_empty;
    assign fsm_state  = state;

    always_ff @(posedge LClk) begin
        if (LRst) begin
            state     <= IDLE;
            cur       <= '0;
            timer     <= '0;
            remain    <= '0;
            ST_CLK    <= 1'b0;
            ST_DIR    <= 1'b0;
            ST_ENB    <= 1'b0;
            move_done <= 1'b0;
            cmd_ovf   <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            remain    <= remain_next;
            ST_CLK    <= (state_next == HIGH);
            ST_DIR    <= dir_next;
            ST_ENB    <= enb_next;
            move_done <= done_evt;
            cmd_ovf   <= cmd_wr && cmd_full && !abort;
            if (pop) cur <= fifo_rdata;
        end
    end

`ifdef STEP_POS_CNT_EN
    always_ff @(posedge LClk) begin
        if (LRst) begin
            position <= '0;
        end else if (state_next == HIGH && state != HIGH) begin
            position <= ST_DIR ? position - 32'sd1 : position + 32'sd1;
        end
    end
`endif

    always_comb begin
        state_next  = state;
        timer_next  = timer;
        remain_next = remain;
        dir_next    = ST_DIR;
        pop         = 1'b0;
        done_evt    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                remain_next = cur.steps;
                if (cur.steps == 16'd0) begin
                    done_evt   = 1'b1;
                    state_next = IDLE;
                end else if (cur.dir != ST_DIR) begin
                    dir_next   = cur.dir;
                    timer_next = SETUP_LOAD;
                    state_next = DSETUP;
                end else begin
                    timer_next = half_len - 32'd1;
                    state_next = HIGH;
                end
            end
            DSETUP: begin
                if (timer == 32'd0) begin
                    timer_next = half_len - 32'd1;
                    state_next = HIGH;
                end else begin
                    timer_next = timer - 32'd1;
                end
            end
            HIGH: begin
                if (timer == 32'd0) begin
                    timer_next = low_len - 32'd1;
                    state_next = LOW;
                end else begin
                    timer_next = timer - 32'd1;
                end
            end
            LOW: begin
                if (timer == 32'd0) begin
                    remain_next = remain - 16'd1;
                    if (remain == 16'd1) begin
                        done_evt   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        timer_next = half_len - 32'd1;
                        state_next = HIGH;
                    end
                end else begin
                    timer_next = timer - 32'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
            dir_next   = ST_DIR;
            pop        = 1'b0;
            done_evt   = 1'b0;
        end
        // enable holds through an IDLE that will immediately pop another command
        enb_next = !abort && ((state_next != IDLE) ||
                              ((state != IDLE) && (!fifo_empty || wr_acc)));
    end

endmodule

// File: tb/tb_step_move_seq.sv
// Directed bench for step_move_seq: table of single moves plus queue, abort and reset sequences.
module tb_step_move_seq;
    import step_move_seq_pkg::*;

    logic               LClk = 1'b0;
    logic               LRst;
    logic               cmd_wr;
    logic [31:0]        cmd_period;
    logic [15:0]        cmd_steps;
    logic               cmd_dir;
    logic               abort;
    logic               cmd_full;
    logic               cmd_ovf;
    logic [4:0]         q_level;
    logic               ST_CLK;
    logic               ST_DIR;
    logic               ST_ENB;
    logic               busy;
    logic               move_done;
`ifdef STEP_POS_CNT_EN
    logic signed [31:0] position;
`endif
    state_t             fsm_state;

    int errors = 0;
    int checks = 0;

    step_move_seq dut (
        .LClk       (LClk),
        .LRst       (LRst),
        .cmd_wr     (cmd_wr),
        .cmd_period (cmd_period),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .abort      (abort),
        .cmd_full   (cmd_full),
        .cmd_ovf    (cmd_ovf),
        .q_level    (q_level),
        .ST_CLK     (ST_CLK),
        .ST_DIR     (ST_DIR),
        .ST_ENB     (ST_ENB),
        .busy       (busy),
        .move_done  (move_done),
`ifdef STEP_POS_CNT_EN
        .position   (position),
`endif
        .fsm_state  (fsm_state)
    );

    always #5 LClk = ~LClk;

    typedef struct {
        logic [31:0] period;
        logic [15:0] steps;
        logic        dir;
        int          first;
        int          high;
        int          low;
        int          pulses;
        int          done_k;
        bit          dir_chg;
        int          pos;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge LClk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_pos(input string name, input int exp);
`ifdef STEP_POS_CNT_EN
        check(name, 32'(position), 32'(exp));
`endif
    endtask

    task automatic put_cmd(input logic [31:0] p, input logic [15:0] s, input logic d);
        cmd_period = p;
        cmd_steps  = s;
        cmd_dir    = d;
    endtask

    task automatic wait_clk_high(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (ST_CLK) seen = 1;
            else tick();
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic run_row(input int i);
        vec_t v = tbl[i];
        int   k = 1;
        int   rises = 0;
        int   first_k = 0;
        int   rise_k = 0;
        int   fall_k = 0;
        int   done_k = 0;
        int   dir_k = 0;
        bit   done = 0;
        logic prev_clk = 1'b0;
        logic prev_dir = ST_DIR;
        put_cmd(v.period, v.steps, v.dir);
        cmd_wr = 1'b1;
        tick();
        cmd_wr = 1'b0;
        while (!done && k <= 300) begin
            if (ST_CLK && !prev_clk) begin
                rises++;
                if (rises == 1) begin
                    first_k = k;
                    check($sformatf("row%0d_enb_on", i), 32'(ST_ENB), 32'd1);
                end else begin
                    check($sformatf("row%0d_low", i), 32'(k - fall_k), 32'(v.low));
                end
                rise_k = k;
            end
            if (!ST_CLK && prev_clk) begin
                check($sformatf("row%0d_high", i), 32'(k - rise_k), 32'(v.high));
                fall_k = k;
            end
            if (ST_DIR !== prev_dir) dir_k = k;
            if (move_done) begin
                done   = 1;
                done_k = k;
                if (rises > 0) check($sformatf("row%0d_last_low", i), 32'(k - fall_k), 32'(v.low));
            end
            prev_clk = ST_CLK;
            prev_dir = ST_DIR;
            if (!done) begin
                tick();
                k++;
            end
        end
        check($sformatf("row%0d_done_seen", i), 32'(done), 32'd1);
        check($sformatf("row%0d_first_rise", i), 32'(first_k), 32'(v.first));
        check($sformatf("row%0d_pulses", i), 32'(rises), 32'(v.pulses));
        check($sformatf("row%0d_done_cycle", i), 32'(done_k), 32'(v.done_k));
        check($sformatf("row%0d_enb_off", i), 32'(ST_ENB), 32'd0);
        check($sformatf("row%0d_dir", i), 32'(ST_DIR), 32'(v.dir));
        if (v.dir_chg) check($sformatf("row%0d_dir_setup", i), 32'(first_k - dir_k), 32'd16);
        check_pos($sformatf("row%0d_position", i), v.pos);
        tick();
        check($sformatf("row%0d_done_width", i), 32'(move_done), 32'd0);
    endtask

    initial begin
        int exp_lvl [5];
        int md_cnt;
        int rise_cnt;
        logic prev;

        //           period steps dir first high low pulses done chg pos
        tbl[0] = '{32'd10, 16'd3, 1'b0,  3, 5, 5, 3, 33, 1'b0,  3};
        tbl[1] = '{32'd10, 16'd2, 1'b1, 19, 5, 5, 2, 39, 1'b1,  1};
        tbl[2] = '{32'd1,  16'd2, 1'b1,  3, 2, 2, 2, 11, 1'b0, -1};
        tbl[3] = '{32'd7,  16'd2, 1'b0, 19, 3, 4, 2, 33, 1'b1,  1};
        tbl[4] = '{32'd4,  16'd1, 1'b0,  3, 2, 2, 1,  7, 1'b0,  2};
        tbl[5] = '{32'd0,  16'd0, 1'b0,  0, 0, 0, 0,  3, 1'b0,  2};

        LRst   = 1'b1;
        cmd_wr = 1'b0;
        abort  = 1'b0;
        put_cmd(32'd0, 16'd0, 1'b0);
        repeat (3) tick();
        LRst = 1'b0;
        tick();
        check("rst_st_clk", 32'(ST_CLK), 32'd0);
        check("rst_st_dir", 32'(ST_DIR), 32'd0);
        check("rst_st_enb", 32'(ST_ENB), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_move_done", 32'(move_done), 32'd0);
        check("rst_cmd_ovf", 32'(cmd_ovf), 32'd0);
        check("rst_q_level", 32'(q_level), 32'd0);
        check("rst_cmd_full", 32'(cmd_full), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        check_pos("rst_position", 0);

        for (int i = 0; i < 6; i++) run_row(i);

        // five zero-step writes from idle: the FSM pops between them, so none drop
        exp_lvl = '{1, 1, 2, 2, 3};
        md_cnt   = 0;
        rise_cnt = 0;
        put_cmd(32'd10, 16'd0, 1'b0);
        cmd_wr = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            if (j == 4) cmd_wr = 1'b0;
            check($sformatf("idle_q_level_%0d", j), 32'(q_level), 32'(exp_lvl[j]));
            check($sformatf("idle_ovf_%0d", j), 32'(cmd_ovf), 32'd0);
            if (move_done) md_cnt++;
            if (ST_CLK) rise_cnt++;
        end
        for (int j = 0; j < 11; j++) begin
            tick();
            if (move_done) md_cnt++;
            if (ST_CLK) rise_cnt++;
        end
        check("idle_done_count", 32'(md_cnt), 32'd5);
        check("idle_no_st_clk", 32'(rise_cnt), 32'd0);
        check("idle_busy_end", 32'(busy), 32'd0);
        check("idle_enb_end", 32'(ST_ENB), 32'd0);

        // long move occupies the FSM; five more writes overflow on the fifth
        put_cmd(32'd200, 16'd1, 1'b1);
        cmd_wr = 1'b1;
        tick();
        cmd_wr = 1'b0;
        wait_clk_high("busy_clk_wait", 40);
        exp_lvl = '{1, 2, 3, 4, 4};
        put_cmd(32'd10, 16'd0, 1'b0);
        cmd_wr = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            if (j == 4) cmd_wr = 1'b0;
            check($sformatf("busy_q_level_%0d", j), 32'(q_level), 32'(exp_lvl[j]));
            check($sformatf("busy_full_%0d", j), 32'(cmd_full), 32'(exp_lvl[j] == 4));
            check($sformatf("busy_ovf_%0d", j), 32'(cmd_ovf), 32'(j == 4));
            check($sformatf("busy_st_clk_%0d", j), 32'(ST_CLK), 32'd1);
        end

        // abort mid-HIGH with a write into the full queue
        abort  = 1'b1;
        cmd_wr = 1'b1;
        tick();
        abort  = 1'b0;
        cmd_wr = 1'b0;
        check("abort_st_clk", 32'(ST_CLK), 32'd0);
        check("abort_q_level", 32'(q_level), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_move_done", 32'(move_done), 32'd0);
        check("abort_ovf", 32'(cmd_ovf), 32'd0);
        check("abort_enb", 32'(ST_ENB), 32'd0);
        check("abort_dir_hold", 32'(ST_DIR), 32'd1);
        check("abort_state", 32'(fsm_state), 32'(IDLE));
        check_pos("abort_position", 1);
        md_cnt   = 0;
        rise_cnt = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (move_done) md_cnt++;
            if (ST_CLK) rise_cnt++;
        end
        check("abort_quiet_done", 32'(md_cnt), 32'd0);
        check("abort_quiet_clk", 32'(rise_cnt), 32'd0);

        // reset mid-move, with abort and cmd_wr also asserted
        put_cmd(32'd10, 16'd5, 1'b0);
        cmd_wr = 1'b1;
        tick();
        cmd_wr = 1'b0;
        wait_clk_high("rst_mid_clk_wait", 40);
        prev = ST_CLK;
        check("rst_mid_pre_clk", 32'(prev), 32'd1);
        LRst   = 1'b1;
        abort  = 1'b1;
        cmd_wr = 1'b1;
        tick();
        LRst   = 1'b0;
        abort  = 1'b0;
        cmd_wr = 1'b0;
        check("rst_mid_st_clk", 32'(ST_CLK), 32'd0);
        check("rst_mid_st_dir", 32'(ST_DIR), 32'd0);
        check("rst_mid_st_enb", 32'(ST_ENB), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_move_done", 32'(move_done), 32'd0);
        check("rst_mid_ovf", 32'(cmd_ovf), 32'd0);
        check("rst_mid_q_level", 32'(q_level), 32'd0);
        check_pos("rst_mid_position", 0);
        tick();
        check("rst_mid_q_after", 32'(q_level), 32'd0);
        check("rst_mid_busy_after", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/step_move_seq.md
STEP_MOVE_SEQ -- requirements
Module: step_move_seq

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, command queue depth (power of 2, 2..16).
REQ-002 SHALL have parameter DIR_SETUP, default 16, LClk cycles between an ST_DIR change and the next ST_CLK rise.
REQ-003 SHALL have parameter MIN_PERIOD, default 4, lower clamp on step period in LClk cycles.
REQ-004 LClk  in  1  sole clock; all logic on rising edge.
REQ-005 LRst  in  1  reset; synchronous, active-high.
REQ-006 cmd_wr  in  1  one-cycle write strobe for a move command.
REQ-007 cmd_period  in  32  step period in LClk cycles.
REQ-008 cmd_steps  in  16  step count.
REQ-009 cmd_dir  in  1  direction for the move.
REQ-010 abort  in  1  stop motion and flush the queue.
REQ-011 cmd_full  out  1  queue holds QDEPTH entries.
REQ-012 cmd_ovf  out  1  one-cycle pulse when cmd_wr is dropped.
REQ-013 q_level  out  5  queued entry count.
REQ-014 ST_CLK / ST_DIR / ST_ENB  out  1 each  stepper clock, direction and enable.
REQ-015 busy  out  1  FSM not IDLE or queue non-empty.
REQ-016 move_done  out  1  one-cycle pulse at completion of each command.

Function
REQ-017 cmd_wr with cmd_full=0 SHALL enqueue {period,steps,dir}; cmd_wr with cmd_full=1 SHALL drop the write and pulse cmd_ovf next cycle, even if a pop occurs the same cycle.
REQ-018 States SHALL be IDLE, LOAD, DSETUP, HIGH, LOW.
REQ-019 IDLE: queue non-empty -> pop, go LOAD; ST_ENB SHALL be 1 from the first LOAD until return to IDLE with an empty queue.
REQ-020 LOAD: eff_period = max(cmd_period, MIN_PERIOD); steps==0 -> pulse move_done, go IDLE; cmd_dir!=ST_DIR -> update ST_DIR, go DSETUP; else go HIGH.
REQ-021 DSETUP SHALL last exactly DIR_SETUP cycles, then HIGH.
REQ-022 HIGH SHALL last eff_period>>1 cycles; LOW SHALL last eff_period-(eff_period>>1) cycles; ST_CLK SHALL be registered and equal 1 exactly during HIGH.
REQ-023 At the end of LOW the remaining count SHALL decrement; zero -> pulse move_done, go IDLE; else HIGH.
REQ-024 Latency: cmd_wr at cycle N into an empty queue in IDLE with no direction change SHALL give the first ST_CLK=1 at cycle N+3.
REQ-025 abort SHALL take priority over all events: next cycle FSM=IDLE, ST_CLK=0, queue emptied, no move_done; ST_DIR holds; a cmd_wr in the abort cycle SHALL be discarded without cmd_ovf.
REQ-026 Step and period counters SHALL be 16/32-bit unsigned with no wrap; eff_period arithmetic SHALL be 32-bit.

Reset
REQ-027 LRst SHALL clear the queue and set FSM=IDLE, ST_CLK=0, ST_DIR=0, ST_ENB=0, busy=0, move_done=0, cmd_ovf=0, q_level=0, position=0; LRst SHALL override abort and cmd_wr.

Configuration
REQ-028 With STEP_POS_CNT_EN defined, SHALL add output position (32, signed): +1 per ST_CLK rise when ST_DIR=0, -1 when ST_DIR=1, wrapping at 32 bits, unaffected by abort.
REQ-029 Without STEP_POS_CNT_EN, the position port and its counter SHALL be absent.

Structure
REQ-030 A shared package SHALL hold the state enum, the command record type {period[31:0], steps[15:0], dir}, and the MIN_PERIOD/DIR_SETUP defaults.
REQ-031 Queue SHALL be one sub-module, step_cmd_fifo (sync FIFO, flush input); FSM and timers stay in step_move_seq.

Verification
REQ-032 Reset, write {period=10, steps=3, dir=0} -> first ST_CLK rise 3 cycles after cmd_wr; 3 pulses of 5 high/5 low; one move_done; ST_ENB falls afterwards.
REQ-033 After REQ-032, write {10,2,dir=1} -> ST_DIR=1 in LOAD, exactly 16 DSETUP cycles, then 2 pulses; position (if enabled) 3 -> 1.
REQ-034 Write period=1, steps=2 -> clamped to 4: 2 high/2 low per step.
REQ-035 Write 5 commands back-to-back while idle, QDEPTH=4 -> the 5th write drops unless a pop occurred first; check cmd_ovf and q_level per cycle; steps=0 entry -> move_done with no ST_CLK.
REQ-036 abort mid-HIGH with 2 queued -> ST_CLK=0, q_level=0, busy=0 next cycle; no move_done.
REQ-037 LRst mid-move -> all outputs at reset values next cycle.
